// File: rtl/lcd_text_refresh_ctrl.sv
// lcd_text_refresh_ctrl
//   HD44780-compatible character LCD controller, 4-bit bus, write-only.
//   After reset it runs the power-on init sequence, then refreshes a
//   ROWS x COLS text window forever. Each character is fetched through a
//   combinational index/char lookup answered by the parent core.
//
//   Build option: define LCD_HOLD_EN to add the 'hold' input, which parks
//   the refresh loop in IDLE at the end of a frame while asserted.
//
// Ports
//   CLK        in   system clock
//   rst_n      in   asynchronous active-low reset
//   hold       in   (LCD_HOLD_EN only) park after the current frame
//   index      out  [7:0] DDRAM address of the requested character
//   char_i     in   [7:0] ASCII code for index, same cycle
//   lcd_rs     out  0 = command, 1 = data
//   lcd_rw     out  tied 0
//   lcd_e      out  enable strobe
//   lcd_data   out  [3:0] nibble bus
//   ready      out  high once init has completed
//   frame_done out  one-cycle pulse at the end of every frame
module lcd_text_refresh_ctrl #(
  parameter int CYC_PER_US = 50,
  parameter int ROWS       = 2,
  parameter int COLS       = 16,
  parameter int E_CYC      = 12
) (
  input  logic       CLK,
  input  logic       rst_n,
`ifdef LCD_HOLD_EN
  input  logic       hold,
`endif
  output logic [7:0] index,
  input  logic [7:0] char_i,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [3:0] lcd_data,
  output logic       ready,
  output logic       frame_done
);

  if (ROWS < 1 || ROWS > 4) begin : g_err_rows
    $error("lcd_text_refresh_ctrl: ROWS must be in 1..4");
  end
  if (COLS < 1 || COLS > 20) begin : g_err_cols
    $error("lcd_text_refresh_ctrl: COLS must be in 1..20");
  end
  if (CYC_PER_US < 1 || E_CYC < 1) begin : g_err_time
    $error("lcd_text_refresh_ctrl: CYC_PER_US and E_CYC must be >= 1");
  end

  localparam int CW = $clog2(15000 * CYC_PER_US + E_CYC + 2);

  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] C_PWRUP = CW'(15000 * CYC_PER_US - 1);
  localparam logic [CW-1:0] C_E     = CW'(E_CYC - 1);
  localparam logic [CW-1:0] D1      = CW'(CYC_PER_US - 1);
  localparam logic [CW-1:0] D40     = CW'(40 * CYC_PER_US - 1);
  localparam logic [CW-1:0] D100    = CW'(100 * CYC_PER_US - 1);
  localparam logic [CW-1:0] D1640   = CW'(1640 * CYC_PER_US - 1);
  localparam logic [CW-1:0] D4100   = CW'(4100 * CYC_PER_US - 1);

  localparam logic [1:0] ROW_LAST = 2'(ROWS - 1);
  localparam logic [4:0] COL_LAST = 5'(COLS - 1);

  typedef enum logic [2:0] {
    PWRUP, NIB_SETUP, NIB_PULSE, NIB_HOLD, DELAY, IDLE
  } state_e;

  // Rows 2/3 continue rows 0/1 in DDRAM on 4-line panels.
  function automatic logic [7:0] row_base(input logic [1:0] r);
    case (r)
      2'd0:    row_base = 8'h00;
      2'd1:    row_base = 8'h40;
      2'd2:    row_base = 8'(COLS);
      default: row_base = 8'(64 + COLS);
    endcase
  endfunction

  // Steps 0..3 are single nibbles (carried in the high half), 4..7 bytes.
  function automatic logic [7:0] init_byte(input logic [2:0] s);
    case (s)
      3'd0, 3'd1, 3'd2: init_byte = 8'h30;
      3'd3:             init_byte = 8'h20;
      3'd4:             init_byte = 8'h28;
      3'd5:             init_byte = 8'h06;
      3'd6:             init_byte = 8'h0C;
      default:          init_byte = 8'h01;
    endcase
  endfunction

  logic hold_w;
`ifdef LCD_HOLD_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    data_q, data_d;
  logic [3:0]    lo_nib_q, lo_nib_d;
  logic [7:0]    idx_q, idx_d;
  logic          rs_q, rs_d;
  logic          lo_q, lo_d;         // low nibble of a byte in flight
  logic          single_q, single_d; // current item is a lone init nibble
  logic          isdata_q, isdata_d; // current byte is a character
  logic [2:0]    step_q, step_d;
  logic [1:0]    row_q, row_d;
  logic [4:0]    col_q, col_d;
  logic          ready_q, ready_d;
  logic          fdone_q, fdone_d;

  // Sequencing: decides what goes on the bus next. Kept free of char_i so
  // index (and thus the parent's char lookup) never loops back into it.
  logic       launch, lo_start, park;
  logic       l_data, l_single;
  logic [7:0] l_cmd, l_idx;
  logic [1:0] l_row;
  logic [4:0] l_col;

  always_comb begin : seq_ctl
    launch   = 1'b0;
    lo_start = 1'b0;
    park     = 1'b0;
    l_data   = 1'b0;
    l_single = 1'b0;
    l_cmd    = 8'h00;
    l_row    = row_q;
    l_col    = col_q;
    step_d   = step_q;
    row_d    = row_q;
    col_d    = col_q;
    ready_d  = ready_q;
    fdone_d  = 1'b0;
    case (state_q)
      PWRUP: if (cnt_q == '0) begin
        launch   = 1'b1;
        l_single = 1'b1;
        l_cmd    = init_byte(3'd0);
      end
      DELAY: if (cnt_q == '0) begin
        if (!single_q && !lo_q) begin
          lo_start = 1'b1;
        end else if (!ready_q) begin
          if (step_q == 3'd7) begin
            ready_d = 1'b1;
            launch  = 1'b1;
            l_cmd   = 8'h80 | row_base(2'd0);
          end else begin
            step_d   = step_q + 3'd1;
            launch   = 1'b1;
            l_single = ~step_d[2];
            l_cmd    = init_byte(step_d);
          end
        end else if (!isdata_q) begin
          launch = 1'b1;
          l_data = 1'b1;
        end else if (col_q != COL_LAST) begin
          col_d  = col_q + 5'd1;
          l_col  = col_d;
          launch = 1'b1;
          l_data = 1'b1;
        end else begin
          col_d = 5'd0;
          if (row_q != ROW_LAST) begin
            row_d  = row_q + 2'd1;
            launch = 1'b1;
            l_cmd  = 8'h80 | row_base(row_d);
          end else begin
            row_d   = 2'd0;
            fdone_d = 1'b1;
            if (hold_w) begin
              park = 1'b1;
            end else begin
              launch = 1'b1;
              l_cmd  = 8'h80 | row_base(2'd0);
            end
          end
        end
      end
      IDLE: if (!hold_w) begin
        launch = 1'b1;
        l_cmd  = 8'h80 | row_base(2'd0);
      end
      default: ;
    endcase
    l_idx = l_data ? row_base(l_row) + {3'b000, l_col} : 8'h00;
  end

  // Post-nibble gap: 1 us between halves of a byte, otherwise the item's delay.
  logic [CW-1:0] dly;
  always_comb begin : gap_sel
    dly = D40;
    if (single_q) begin
      case (step_q)
        3'd0:    dly = D4100;
        3'd1:    dly = D100;
        default: dly = D40;
      endcase
    end else if (!lo_q) begin
      dly = D1;
    end else if (!ready_q && step_q == 3'd7) begin
      dly = D1640;
    end
  end

  logic [7:0] l_byte;
  always_comb begin : nib_fsm
    state_d  = state_q;
    cnt_d    = (cnt_q != '0) ? cnt_q - ONE : cnt_q;
    data_d   = data_q;
    lo_nib_d = lo_nib_q;
    idx_d    = idx_q;
    rs_d     = rs_q;
    lo_d     = lo_q;
    single_d = single_q;
    isdata_d = isdata_q;
    l_byte   = l_data ? char_i : l_cmd;
    case (state_q)
      NIB_SETUP: if (cnt_q == '0) begin
        state_d = NIB_PULSE;
        cnt_d   = C_E;
      end
      NIB_PULSE: if (cnt_q == '0) state_d = NIB_HOLD;
      NIB_HOLD: begin
        state_d = DELAY;
        cnt_d   = dly;
      end
      default: ;
    endcase
    if (lo_start) begin
      data_d  = lo_nib_q;
      lo_d    = 1'b1;
      state_d = NIB_SETUP;
      cnt_d   = ONE;
    end
    if (park) state_d = IDLE;
    // The character is captured on the edge that enters NIB_SETUP.
    if (launch) begin
      data_d   = l_byte[7:4];
      lo_nib_d = l_byte[3:0];
      rs_d     = l_data;
      idx_d    = l_idx;
      lo_d     = 1'b0;
      single_d = l_single;
      isdata_d = l_data;
      state_d  = NIB_SETUP;
      cnt_d    = ONE;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PWRUP;
      cnt_q    <= C_PWRUP;
      data_q   <= 4'h0;
      lo_nib_q <= 4'h0;
      idx_q    <= 8'h00;
      rs_q     <= 1'b0;
      lo_q     <= 1'b0;
      single_q <= 1'b0;
      isdata_q <= 1'b0;
      step_q   <= 3'd0;
      row_q    <= 2'd0;
      col_q    <= 5'd0;
      ready_q  <= 1'b0;
      fdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      lo_nib_q <= lo_nib_d;
      idx_q    <= idx_d;
      rs_q     <= rs_d;
      lo_q     <= lo_d;
      single_q <= single_d;
      isdata_q <= isdata_d;
      step_q   <= step_d;
      row_q    <= row_d;
      col_q    <= col_d;
      ready_q  <= ready_d;
      fdone_q  <= fdone_d;
    end
  end

  // index shows the new address in the launch cycle so char_i is valid there.
  assign index      = launch ? l_idx : idx_q;
  assign lcd_e      = (state_q == NIB_PULSE);
  assign lcd_rw     = 1'b0;
  assign lcd_rs     = rs_q;
  assign lcd_data   = data_q;
  assign ready      = ready_q;
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_lcd_text_refresh_ctrl.sv
module tb_lcd_text_refresh_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
`ifdef LCD_HOLD_EN
  logic hold = 1'b0;
`endif

  logic [7:0] idx_a, chr_a, idx_b, chr_b;
  logic       rs_a, rw_a, e_a, rdy_a, fd_a_o;
  logic       rs_b, rw_b, e_b, rdy_b, fd_b_o;
  logic [3:0] data_a, data_b;

  // Character source: char = index + 0x20.
  assign chr_a = idx_a + 8'h20;
  assign chr_b = idx_b + 8'h20;

  lcd_text_refresh_ctrl #(.CYC_PER_US(1), .ROWS(2), .COLS(16), .E_CYC(2)) dut_a (
    .CLK(clk), .rst_n(rst_n),
`ifdef LCD_HOLD_EN
    .hold(hold),
`endif
    .index(idx_a), .char_i(chr_a), .lcd_rs(rs_a), .lcd_rw(rw_a), .lcd_e(e_a),
    .lcd_data(data_a), .ready(rdy_a), .frame_done(fd_a_o));

  lcd_text_refresh_ctrl #(.CYC_PER_US(1), .ROWS(4), .COLS(20), .E_CYC(2)) dut_b (
    .CLK(clk), .rst_n(rst_n),
`ifdef LCD_HOLD_EN
    .hold(hold),
`endif
    .index(idx_b), .char_i(chr_b), .lcd_rs(rs_b), .lcd_rw(rw_b), .lcd_e(e_b),
    .lcd_data(data_b), .ready(rdy_b), .frame_done(fd_b_o));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  int cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  // ---------------- scoreboards ----------------
  logic [4:0] exp_a[$];   // {rs, nibble}
  logic [8:0] exp_b[$];   // {rs, byte}

  task automatic push_a_byte(input logic rs, input logic [7:0] b);
    exp_a.push_back({rs, b[7:4]});
    exp_a.push_back({rs, b[3:0]});
  endtask

  task automatic push_a_init();
    exp_a.push_back(5'h03);
    exp_a.push_back(5'h03);
    exp_a.push_back(5'h03);
    exp_a.push_back(5'h02);
    push_a_byte(1'b0, 8'h28);
    push_a_byte(1'b0, 8'h06);
    push_a_byte(1'b0, 8'h0C);
    push_a_byte(1'b0, 8'h01);
  endtask

  task automatic push_a_frame();
    push_a_byte(1'b0, 8'h80);
    for (int c = 0; c < 16; c++) push_a_byte(1'b1, 8'h20 + 8'(c));
    push_a_byte(1'b0, 8'hC0);
    for (int c = 0; c < 16; c++) push_a_byte(1'b1, 8'h60 + 8'(c));
  endtask

  task automatic push_b_frame();
    logic [7:0] cmds [4];
    logic [7:0] bases[4];
    cmds  = '{8'h80, 8'hC0, 8'h94, 8'hD4};
    bases = '{8'h00, 8'h40, 8'h14, 8'h54};
    for (int r = 0; r < 4; r++) begin
      exp_b.push_back({1'b0, cmds[r]});
      for (int c = 0; c < 20; c++) exp_b.push_back({1'b1, bases[r] + 8'(c) + 8'h20});
    end
  endtask

  // ---------------- monitor A: nibble scoreboard + strobe timing ----------------
  int rise_a[8];
  int fall_a[8];
  int np_a, nib_since_a, fd_a, rdy_cyc_a, elen_a;

  initial begin
    logic       pe, prdy, pfd;
    logic [4:0] s1, s2, cur, now;
    pe = 0; prdy = 0; pfd = 0; s1 = 0; s2 = 0; cur = 0;
    np_a = 0; nib_since_a = 0; fd_a = 0; rdy_cyc_a = -1; elen_a = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pe = 0; prdy = 0; pfd = 0; s1 = 0; s2 = 0; np_a = 0; nib_since_a = 0; elen_a = 0;
      end else begin
        now = {rs_a, data_a};
        if (e_a && !pe) begin
          check("a_setup_stable", {s2, s1}, {now, now});
          check("a_rw", rw_a, 0);
          if (exp_a.size() == 0) check("a_scoreboard_empty", 1, 0);
          else check("a_nibble", now, exp_a.pop_front());
          if (!rs_a) check("a_cmd_index", idx_a, 0);
          if (np_a < 8) rise_a[np_a] = cyc;
          cur = now; elen_a = 0; nib_since_a++;
        end
        if (e_a) elen_a++;
        if (!e_a && pe) begin
          check("a_e_width", elen_a, 2);
          check("a_hold", now, cur);
          if (np_a < 8) fall_a[np_a] = cyc;
          np_a++;
        end
        if (rdy_a && !prdy) begin rdy_cyc_a = cyc; nib_since_a = 0; end
        if (fd_a_o) begin
          check("a_fd_one_cycle", pfd, 0);
          check("a_frame_nibbles", nib_since_a, 68);
          nib_since_a = 0; fd_a++;
        end
        pe = e_a; prdy = rdy_a; pfd = fd_a_o; s2 = s1; s1 = now;
      end
    end
  end

  // ---------------- monitor B: byte scoreboard for 4x20 geometry ----------------
  int nib_b, fd_b, rdy_cyc_b;
  initial begin
    logic       pe, prdy;
    logic [3:0] hi;
    pe = 0; prdy = 0; hi = 0; nib_b = 0; fd_b = 0; rdy_cyc_b = -1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pe = 0; prdy = 0; nib_b = 0;
      end else begin
        if (rdy_b && !prdy) begin rdy_cyc_b = cyc; nib_b = 0; end
        if (e_b && !pe && rdy_b) begin
          if (nib_b % 2 == 0) begin
            hi = data_b;
            if (rs_b) check("b_index_max", 32'(idx_b <= 8'h67), 1);
          end else if (exp_b.size() != 0) begin
            check("b_byte", {rs_b, hi, data_b}, exp_b.pop_front());
          end
          nib_b++;
        end
        if (fd_b_o) begin
          if (fd_b == 0) check("b_frame_nibbles", nib_b, 168);
          fd_b++; nib_b = 0;
        end
        pe = e_b; prdy = rdy_b;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs_a", {e_a, rs_a, rw_a, data_a, idx_a, rdy_a, fd_a_o}, 0);
    check("reset_outputs_b", {e_b, rs_b, rw_b, data_b, idx_b, rdy_b, fd_b_o}, 0);
    push_a_init();
    for (int f = 0; f < 5; f++) push_a_frame();
    push_b_frame();
    rst_n = 1'b1;

    for (int i = 0; i < 30000 && !rdy_a; i++) @(negedge clk);
    check("a_ready_seen", rdy_a, 1);
    // 15000 + singles(4105+105+45+45) + bytes(3*51 + 1651)
    check("a_ready_cycle", rdy_cyc_a, 21104);
    check("b_ready_cycle", rdy_cyc_b, 21104);
    check("a_first_rise", rise_a[0], 15002);
    check("a_gap_4100", rise_a[1] - fall_a[0], 4103);
    check("a_gap_100", rise_a[2] - fall_a[1], 103);
    check("a_gap_40", rise_a[3] - fall_a[2], 43);
    check("a_gap_intra_byte", rise_a[5] - fall_a[4], 4);
    check("a_gap_after_byte", rise_a[6] - fall_a[5], 43);

    for (int i = 0; i < 10000 && !(fd_a >= 2 && fd_b >= 1); i++) @(negedge clk);
    check("a_two_frames", 32'(fd_a >= 2), 1);
    check("b_one_frame", 32'(fd_b >= 1), 1);
    check("b_all_bytes_seen", exp_b.size(), 0);

`ifdef LCD_HOLD_EN
    begin
      int f0, edges;
      logic pe;
      repeat (200) @(negedge clk);
      hold = 1'b1;
      f0 = fd_a;
      for (int i = 0; i < 3000 && fd_a == f0; i++) @(negedge clk);
      check("hold_frame_completed", 32'(fd_a > f0), 1);
      edges = 0; pe = e_a;
      repeat (1000) begin
        @(negedge clk);
        if (e_a && !pe) edges++;
        pe = e_a;
      end
      check("hold_no_strobes", edges, 0);
      hold = 1'b0;
      for (int i = 0; i < 20 && !e_a; i++) @(negedge clk);
      check("hold_resume_nibble", {e_a, rs_a, data_a}, 6'h28);
    end
`endif

    for (int i = 0; i < 200 && !(rs_a && e_a); i++) @(negedge clk);
    check("a_data_pulse_found", {rs_a, e_a}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("midrst_e", e_a, 0);
    check("midrst_ready", rdy_a, 0);
    check("midrst_outputs", {rs_a, data_a, idx_a, fd_a_o}, 0);
    exp_a.delete();
    repeat (3) @(negedge clk);
    push_a_init();
    rst_n = 1'b1;
    for (int i = 0; i < 16000 && np_a < 1; i++) @(negedge clk);
    check("rerun_pulse_seen", 32'(np_a >= 1), 1);
    check("rerun_first_rise", rise_a[0], 15002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
